// File: rtl/pipe_stage_idex_multi_pkg.sv
// Shared constants and state encoding for the multi-lane ID/EX pipeline stage.
package pipe_stage_idex_multi_pkg;

  localparam int INSTR_W   = 32;
  localparam int LANES_MAX = 8;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_SERIAL = 1'b1
  } idex_state_e;

endpackage

// File: rtl/pipe_stage_idex_multi_serial_ctrl.sv
// Serialisation controller: IDLE/SERIAL FSM, lane counter, registered abort and the one-hot lane-load mask.
// IDEX_SERIAL_SKIP_EN makes serialisation skip lanes whose in_valid_i is low.
module idex_serial_ctrl
  import pipe_stage_idex_multi_pkg::*;
#(
  parameter int LANES = 2,
  parameter int CNT_W = $clog2(LANES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_i,
  input  logic             flush_any_i,
  input  logic             serialize_i,
  input  logic             serialize_abort_i,
  input  logic [LANES-1:0] in_valid_i,
  output logic [LANES-1:0] load_mask_o,
  output logic             stall_up_o,
  output logic             serial_busy_o
);

  idex_state_e      state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [CNT_W-1:0] cur_lane, next_lane;
  logic             abort_r;
  logic             last_step;
  logic             serializing;

  assign serializing = (state == ST_SERIAL) || serialize_i;

  // cur_lane issues this cycle; last_step marks the final lane of the group.
  always_comb begin
    cur_lane  = (state == ST_SERIAL) ? cnt : '0;
    next_lane = '0;
    last_step = 1'b0;
`ifdef IDEX_SERIAL_SKIP_EN
    if (state == ST_IDLE) begin
      for (int k = LANES-1; k >= 0; k--) begin
        if (in_valid_i[k]) cur_lane = CNT_W'(k);
      end
    end
    last_step = 1'b1;
    for (int k = LANES-1; k >= 0; k--) begin
      if (in_valid_i[k] && (k > int'(cur_lane))) begin
        next_lane = CNT_W'(k);
        last_step = 1'b0;
      end
    end
`else
    next_lane = cur_lane + CNT_W'(1);
    last_step = (cur_lane == CNT_W'(LANES-1));
`endif
  end

  always_comb begin
    load_mask_o = '1;
    if (serializing) begin
      load_mask_o           = '0;
      load_mask_o[cur_lane] = 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (flush_any_i) begin
      state_nxt = ST_IDLE;
      cnt_nxt   = '0;
    end else if (!stall_i && serializing) begin
      if (last_step) begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end else begin
        state_nxt = ST_SERIAL;
        cnt_nxt   = next_lane;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      abort_r <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      abort_r <= serialize_abort_i;
    end
  end

  // Drops on the final lane so decode advances on the following edge.
  assign stall_up_o    = serialize_i && !abort_r && !last_step;
  assign serial_busy_o = (state == ST_SERIAL);

endmodule

// File: rtl/pipe_stage_idex_multi.sv
// N-lane ID/EX pipeline register with per-lane flush, global stall and one-lane-per-cycle serialisation.
// Optional macro IDEX_SERIAL_SKIP_EN: serialisation skips lanes without a valid instruction.
module pipe_stage_idex_multi
  import pipe_stage_idex_multi_pkg::*;
#(
  parameter  int WIDTH = INSTR_W,
  parameter  int LANES = 2,
  localparam int CNT_W = $clog2(LANES)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall_i,
  input  logic [LANES-1:0]       flush_i,
  input  logic                   serialize_i,
  input  logic                   serialize_abort_i,
  input  logic [LANES-1:0]       in_valid_i,
  input  logic [LANES*WIDTH-1:0] in_data_i,
  output logic [LANES-1:0]       out_valid_o,
  output logic [LANES*WIDTH-1:0] out_data_o,
  output logic                   stall_up_o,
  output logic                   serial_busy_o
);

  logic [LANES-1:0] load_mask;
  logic             flush_any;

  assign flush_any = |flush_i;

  idex_serial_ctrl #(
    .LANES (LANES),
    .CNT_W (CNT_W)
  ) u_ctrl (
    .clk               (clk),
    .rst               (rst),
    .stall_i           (stall_i),
    .flush_any_i       (flush_any),
    .serialize_i       (serialize_i),
    .serialize_abort_i (serialize_abort_i),
    .in_valid_i        (in_valid_i),
    .load_mask_o       (load_mask),
    .stall_up_o        (stall_up_o),
    .serial_busy_o     (serial_busy_o)
  );

  // Any flush freezes unflushed lanes; lanes outside the load mask take a bubble.
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic             valid_q;
    logic [WIDTH-1:0] data_q;

    always_ff @(posedge clk) begin
      if (rst || flush_i[k]) begin
        valid_q <= 1'b0;
        data_q  <= '0;
      end else if (!flush_any && !stall_i) begin
        if (load_mask[k]) begin
          valid_q <= in_valid_i[k];
          data_q  <= in_data_i[k*WIDTH +: WIDTH];
        end else begin
          valid_q <= 1'b0;
          data_q  <= '0;
        end
      end
    end

    assign out_valid_o[k]               = valid_q;
    assign out_data_o[k*WIDTH +: WIDTH] = data_q;
  end

endmodule

// File: tb/tb_pipe_stage_idex_multi.sv
// Scoreboard bench for pipe_stage_idex_multi with LANES=4; expected outputs follow IDEX_SERIAL_SKIP_EN.
module tb_pipe_stage_idex_multi;

  localparam int WIDTH = 32;
  localparam int LANES = 4;
  localparam int DW    = LANES*WIDTH;

  localparam logic [WIDTH-1:0] W0 = 32'h1111_000A;
  localparam logic [WIDTH-1:0] W1 = 32'h2222_000B;
  localparam logic [WIDTH-1:0] W2 = 32'h3333_000C;
  localparam logic [WIDTH-1:0] W3 = 32'h4444_000D;
  localparam logic [DW-1:0]    GRP = {W3, W2, W1, W0};
  localparam logic [DW-1:0]    G2  = {32'hCAFE_0003, 32'hCAFE_0002, 32'hCAFE_0001, 32'hCAFE_0000};
  localparam logic [DW-1:0]    Z   = '0;

  logic             clk = 1'b0;
  logic             rst, stall_i, serialize_i, serialize_abort_i;
  logic [LANES-1:0] flush_i, in_valid_i, out_valid_o;
  logic [DW-1:0]    in_data_i, out_data_o;
  logic             stall_up_o, serial_busy_o;

  typedef struct {
    logic [LANES-1:0] v;
    logic [DW-1:0]    d;
  } exp_t;

  typedef struct {
    logic             rst, stall, ser, abort;
    logic [LANES-1:0] flush, valid;
    logic [DW-1:0]    data;
    logic             chk, up, busy;
    logic [LANES-1:0] ev;
    logic [DW-1:0]    ed;
  } step_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  pipe_stage_idex_multi #(
    .WIDTH (WIDTH),
    .LANES (LANES)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .stall_i           (stall_i),
    .flush_i           (flush_i),
    .serialize_i       (serialize_i),
    .serialize_abort_i (serialize_abort_i),
    .in_valid_i        (in_valid_i),
    .in_data_i         (in_data_i),
    .out_valid_o       (out_valid_o),
    .out_data_o        (out_data_o),
    .stall_up_o        (stall_up_o),
    .serial_busy_o     (serial_busy_o)
  );

  function automatic logic [DW-1:0] ln(input int k, input logic [WIDTH-1:0] w);
    ln = '0;
    ln[k*WIDTH +: WIDTH] = w;
  endfunction

  function automatic step_t mk(input logic r, input logic st, input logic se, input logic ab,
                               input logic [LANES-1:0] fl, input logic [LANES-1:0] va,
                               input logic [DW-1:0] da, input logic ck, input logic up,
                               input logic bz, input logic [LANES-1:0] ev, input logic [DW-1:0] ed);
    mk.rst = r; mk.stall = st; mk.ser = se; mk.abort = ab;
    mk.flush = fl; mk.valid = va; mk.data = da;
    mk.chk = ck; mk.up = up; mk.busy = bz; mk.ev = ev; mk.ed = ed;
  endfunction

  // Drives one cycle of stimulus at the falling edge and queues the registered result it should produce.
  task automatic applyStimulus(input step_t s);
    exp_t e;
    @(negedge clk);
    rst = s.rst; stall_i = s.stall; serialize_i = s.ser; serialize_abort_i = s.abort;
    flush_i = s.flush; in_valid_i = s.valid; in_data_i = s.data;
    e.v = s.ev;
    e.d = s.ed;
    sb.push_back(e);
    #1;
  endtask

  task automatic test_reset();
    step_t s[$];
    exp_t  e;
    s.push_back(mk(1, 0, 0, 0, 4'b0000, 4'b1111, GRP, 0, 0, 0, 4'b0000, Z));
    s.push_back(mk(1, 0, 0, 0, 4'b0000, 4'b1111, GRP, 1, 0, 0, 4'b0000, Z));
    foreach (s[i]) begin
      applyStimulus(s[i]);
      if (s[i].chk) begin
        checks++;
        if (stall_up_o !== s[i].up || serial_busy_o !== s[i].busy) begin
          errors++;
          $display("[TB] FAIL reset ctl step %0d: stall_up=%b busy=%b, expected %b %b", i, stall_up_o, serial_busy_o, s[i].up, s[i].busy);
        end
      end
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if (out_valid_o !== e.v || out_data_o !== e.d) begin
        errors++;
        $display("[TB] FAIL reset out step %0d: valid=%b data=%h, expected %b %h", i, out_valid_o, out_data_o, e.v, e.d);
      end
    end
  endtask

  task automatic test_normal_load();
    step_t s[$];
    exp_t  e;
    s.push_back(mk(0, 0, 0, 0, 4'b0000, 4'b1111, GRP, 1, 0, 0, 4'b1111, GRP));
    s.push_back(mk(0, 0, 0, 0, 4'b0000, 4'b0101, G2,  1, 0, 0, 4'b0101, G2));
    s.push_back(mk(0, 0, 0, 0, 4'b0000, 4'b1111, GRP, 1, 0, 0, 4'b1111, GRP));
    s.push_back(mk(0, 1, 0, 0, 4'b0000, 4'b0000, G2,  1, 0, 0, 4'b1111, GRP));
    s.push_back(mk(0, 0, 0, 0, 4'b0000, 4'b0000, Z,   1, 0, 0, 4'b0000, Z));
    foreach (s[i]) begin
      applyStimulus(s[i]);
      if (s[i].chk) begin
        checks++;
        if (stall_up_o !== s[i].up || serial_busy_o !== s[i].busy) begin
          errors++;
          $display("[TB] FAIL normal ctl step %0d: stall_up=%b busy=%b, expected %b %b", i, stall_up_o, serial_busy_o, s[i].up, s[i].busy);
        end
      end
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if (out_valid_o !== e.v || out_data_o !== e.d) begin
        errors++;
        $display("[TB] FAIL normal out step %0d: valid=%b data=%h, expected %b %h", i, out_valid_o, out_data_o, e.v, e.d);
      end
    end
  endtask

  task automatic test_serialize();
    step_t s[$];
    exp_t  e;
    s.push_back(mk(0, 0, 1, 0, 4'b0000, 4'b1111, GRP, 1, 1, 0, 4'b0001, ln(0, W0)));
    s.push_back(mk(0, 0, 1, 0, 4'b0000, 4'b1111, GRP, 1, 1, 1, 4'b0010, ln(1, W1)));
    s.push_back(mk(0, 0, 1, 0, 4'b0000, 4'b1111, GRP, 1, 1, 1, 4'b0100, ln(2, W2)));
    s.push_back(mk(0, 0, 1, 0, 4'b0000, 4'b1111, GRP, 1, 0, 1, 4'b1000, ln(3, W3)));
    s.push_back(mk(0, 0, 0, 0, 4'b0000, 4'b0000, Z,   1, 0, 0, 4'b0000, Z));
    foreach (s[i]) begin
      applyStimulus(s[i]);
      if (s[i].chk) begin
        checks++;
        if (stall_up_o !== s[i].up || serial_busy_o !== s[i].busy) begin
          errors++;
          $display("[TB] FAIL serialize ctl step %0d: stall_up=%b busy=%b, expected %b %b", i, stall_up_o, serial_busy_o, s[i].up, s[i].busy);
        end
      end
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if (out_valid_o !== e.v || out_data_o !== e.d) begin
        errors++;
        $display("[TB] FAIL serialize out step %0d: valid=%b data=%h, expected %b %h", i, out_valid_o, out_data_o, e.v, e.d);
      end
    end
  endtask

  task automatic test_serialize_stall();
    step_t s[$];
    exp_t  e;
    s.push_back(mk(0, 0, 1, 0, 4'b0000, 4'b1111, GRP, 1, 1, 0, 4'b0001, ln(0, W0)));
    s.push_back(mk(0, 0, 1, 0, 4'b0000, 4'b1111, GRP, 1, 1, 1, 4'b0010, ln(1, W1)));
    for (int j = 0; j < 3; j++)
      s.push_back(mk(0, 1, 1, 0, 4'b0000, 4'b1111, GRP, 1, 1, 1, 4'b0010, ln(1, W1)));
    s.push_back(mk(0, 0, 1, 0, 4'b0000, 4'b1111, GRP, 1, 1, 1, 4'b0100, ln(2, W2)));
    s.push_back(mk(0, 0, 1, 0, 4'b0000, 4'b1111, GRP, 1, 0, 1, 4'b1000, ln(3, W3)));
    s.push_back(mk(0, 0, 0, 0, 4'b0000, 4'b0000, Z,   1, 0, 0, 4'b0000, Z));
    foreach (s[i]) begin
      applyStimulus(s[i]);
      if (s[i].chk) begin
        checks++;
        if (stall_up_o !== s[i].up || serial_busy_o !== s[i].busy) begin
          errors++;
          $display("[TB] FAIL stall ctl step %0d: stall_up=%b busy=%b, expected %b %b", i, stall_up_o, serial_busy_o, s[i].up, s[i].busy);
        end
      end
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if (out_valid_o !== e.v || out_data_o !== e.d) begin
        errors++;
        $display("[TB] FAIL stall out step %0d: valid=%b data=%h, expected %b %h", i, out_valid_o, out_data_o, e.v, e.d);
      end
    end
  endtask

  task automatic test_flush();
    step_t s[$];
    exp_t  e;
    s.push_back(mk(0, 0, 1, 0, 4'b0000, 4'b1111, GRP, 1, 1, 0, 4'b0001, ln(0, W0)));
    s.push_back(mk(0, 0, 1, 0, 4'b0000, 4'b1111, GRP, 1, 1, 1, 4'b0010, ln(1, W1)));
    s.push_back(mk(0, 0, 1, 0, 4'b0100, 4'b1111, GRP, 1, 1, 1, 4'b0010, ln(1, W1)));
    s.push_back(mk(0, 0, 0, 0, 4'b0000, 4'b1111, GRP, 1, 0, 0, 4'b1111, GRP));
    s.push_back(mk(0, 1, 0, 0, 4'b0011, 4'b0000, Z,   1, 0, 0, 4'b1100, {W3, W2, 32'h0, 32'h0}));
    s.push_back(mk(0, 0, 0, 0, 4'b0000, 4'b0000, Z,   1, 0, 0, 4'b0000, Z));
    foreach (s[i]) begin
      applyStimulus(s[i]);
      if (s[i].chk) begin
        checks++;
        if (stall_up_o !== s[i].up || serial_busy_o !== s[i].busy) begin
          errors++;
          $display("[TB] FAIL flush ctl step %0d: stall_up=%b busy=%b, expected %b %b", i, stall_up_o, serial_busy_o, s[i].up, s[i].busy);
        end
      end
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if (out_valid_o !== e.v || out_data_o !== e.d) begin
        errors++;
        $display("[TB] FAIL flush out step %0d: valid=%b data=%h, expected %b %h", i, out_valid_o, out_data_o, e.v, e.d);
      end
    end
  endtask

  task automatic test_abort();
    step_t s[$];
    exp_t  e;
    s.push_back(mk(0, 0, 0, 1, 4'b0000, 4'b0000, Z,   1, 0, 0, 4'b0000, Z));
    s.push_back(mk(0, 0, 1, 1, 4'b0000, 4'b1111, GRP, 1, 0, 0, 4'b0001, ln(0, W0)));
    s.push_back(mk(0, 0, 1, 1, 4'b0000, 4'b1111, GRP, 1, 0, 1, 4'b0010, ln(1, W1)));
    s.push_back(mk(0, 0, 1, 1, 4'b0000, 4'b1111, GRP, 1, 0, 1, 4'b0100, ln(2, W2)));
    s.push_back(mk(0, 0, 1, 1, 4'b0000, 4'b1111, GRP, 1, 0, 1, 4'b1000, ln(3, W3)));
    s.push_back(mk(0, 0, 0, 0, 4'b0000, 4'b0000, Z,   1, 0, 0, 4'b0000, Z));
    s.push_back(mk(0, 0, 1, 1, 4'b0000, 4'b1111, GRP, 1, 1, 0, 4'b0001, ln(0, W0)));
    s.push_back(mk(0, 0, 1, 1, 4'b0000, 4'b1111, GRP, 1, 0, 1, 4'b0010, ln(1, W1)));
    s.push_back(mk(0, 0, 1, 0, 4'b0000, 4'b1111, GRP, 1, 0, 1, 4'b0100, ln(2, W2)));
    s.push_back(mk(0, 0, 1, 0, 4'b0000, 4'b1111, GRP, 1, 0, 1, 4'b1000, ln(3, W3)));
    s.push_back(mk(0, 0, 0, 0, 4'b0000, 4'b0000, Z,   1, 0, 0, 4'b0000, Z));
    foreach (s[i]) begin
      applyStimulus(s[i]);
      if (s[i].chk) begin
        checks++;
        if (stall_up_o !== s[i].up || serial_busy_o !== s[i].busy) begin
          errors++;
          $display("[TB] FAIL abort ctl step %0d: stall_up=%b busy=%b, expected %b %b", i, stall_up_o, serial_busy_o, s[i].up, s[i].busy);
        end
      end
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if (out_valid_o !== e.v || out_data_o !== e.d) begin
        errors++;
        $display("[TB] FAIL abort out step %0d: valid=%b data=%h, expected %b %h", i, out_valid_o, out_data_o, e.v, e.d);
      end
    end
  endtask

  task automatic test_skip();
    step_t s[$];
    exp_t  e;
`ifdef IDEX_SERIAL_SKIP_EN
    s.push_back(mk(0, 0, 1, 0, 4'b0000, 4'b1010, GRP, 1, 1, 0, 4'b0010, ln(1, W1)));
    s.push_back(mk(0, 0, 1, 0, 4'b0000, 4'b1010, GRP, 1, 0, 1, 4'b1000, ln(3, W3)));
    s.push_back(mk(0, 0, 1, 0, 4'b0000, 4'b0100, GRP, 1, 0, 0, 4'b0100, ln(2, W2)));
    s.push_back(mk(0, 0, 0, 0, 4'b0000, 4'b0000, Z,   1, 0, 0, 4'b0000, Z));
`else
    s.push_back(mk(0, 0, 1, 0, 4'b0000, 4'b1010, GRP, 1, 1, 0, 4'b0000, ln(0, W0)));
    s.push_back(mk(0, 0, 1, 0, 4'b0000, 4'b1010, GRP, 1, 1, 1, 4'b0010, ln(1, W1)));
    s.push_back(mk(0, 0, 1, 0, 4'b0000, 4'b1010, GRP, 1, 1, 1, 4'b0000, ln(2, W2)));
    s.push_back(mk(0, 0, 1, 0, 4'b0000, 4'b1010, GRP, 1, 0, 1, 4'b1000, ln(3, W3)));
    s.push_back(mk(0, 0, 0, 0, 4'b0000, 4'b0000, Z,   1, 0, 0, 4'b0000, Z));
`endif
    foreach (s[i]) begin
      applyStimulus(s[i]);
      if (s[i].chk) begin
        checks++;
        if (stall_up_o !== s[i].up || serial_busy_o !== s[i].busy) begin
          errors++;
          $display("[TB] FAIL sparse ctl step %0d: stall_up=%b busy=%b, expected %b %b", i, stall_up_o, serial_busy_o, s[i].up, s[i].busy);
        end
      end
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if (out_valid_o !== e.v || out_data_o !== e.d) begin
        errors++;
        $display("[TB] FAIL sparse out step %0d: valid=%b data=%h, expected %b %h", i, out_valid_o, out_data_o, e.v, e.d);
      end
    end
  endtask

  task automatic test_reset_mid();
    step_t s[$];
    exp_t  e;
    s.push_back(mk(0, 0, 1, 0, 4'b0000, 4'b1111, GRP, 1, 1, 0, 4'b0001, ln(0, W0)));
    s.push_back(mk(0, 0, 1, 0, 4'b0000, 4'b1111, GRP, 1, 1, 1, 4'b0010, ln(1, W1)));
    s.push_back(mk(1, 0, 1, 0, 4'b0000, 4'b1111, GRP, 0, 0, 0, 4'b0000, Z));
    s.push_back(mk(0, 0, 1, 0, 4'b0000, 4'b1111, GRP, 1, 1, 0, 4'b0001, ln(0, W0)));
    s.push_back(mk(0, 0, 1, 0, 4'b0000, 4'b1111, GRP, 1, 1, 1, 4'b0010, ln(1, W1)));
    s.push_back(mk(0, 0, 1, 0, 4'b0000, 4'b1111, GRP, 1, 1, 1, 4'b0100, ln(2, W2)));
    s.push_back(mk(0, 0, 1, 0, 4'b0000, 4'b1111, GRP, 1, 0, 1, 4'b1000, ln(3, W3)));
    s.push_back(mk(0, 0, 0, 0, 4'b0000, 4'b0000, Z,   1, 0, 0, 4'b0000, Z));
    foreach (s[i]) begin
      applyStimulus(s[i]);
      if (s[i].chk) begin
        checks++;
        if (stall_up_o !== s[i].up || serial_busy_o !== s[i].busy) begin
          errors++;
          $display("[TB] FAIL rstmid ctl step %0d: stall_up=%b busy=%b, expected %b %b", i, stall_up_o, serial_busy_o, s[i].up, s[i].busy);
        end
      end
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if (out_valid_o !== e.v || out_data_o !== e.d) begin
        errors++;
        $display("[TB] FAIL rstmid out step %0d: valid=%b data=%h, expected %b %h", i, out_valid_o, out_data_o, e.v, e.d);
      end
    end
  endtask

  initial begin
    rst = 1'b1; stall_i = 1'b0; serialize_i = 1'b0; serialize_abort_i = 1'b0;
    flush_i = '0; in_valid_i = '0; in_data_i = '0;
    $display("[TB] starting pipe_stage_idex_multi bench");
    test_reset();
    test_normal_load();
    test_serialize();
    test_serialize_stall();
    test_flush();
    test_abort();
    test_skip();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
